data_memory: RTL and testbench

Block-granular main data memory that sits directly downstream of the L1 data cache and services its 128-bit block refills and dirty-block write-backs. Accepts one read or write request at a time on the cache's memory-side handshake (READ/WRITE/ADDRESS/WRITEDATA in, READDATA/BUSYWAIT out). Models a fixed multi-cycle access latency with a counter-driven FSM and holds BUSYWAIT high until the access completes.

---
 rtl/data_memory_if.sv | 29 ++
 rtl/data_memory.sv | 135 +++++++++++++
 tb/tb_data_memory.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Memory-side handshake between the L1 data cache (master) and data_memory (slave).
// Latency: n/a (wires only).
// Backpressure: the slave holds BUSYWAIT high while a request is pending or in progress.
interface data_memory_if;
    logic         READ;
    logic         WRITE;
    logic [27:0]  ADDRESS;
    logic [127:0] WRITEDATA;
    logic [127:0] READDATA;
    logic         BUSYWAIT;

    modport master (
        output READ,
        output WRITE,
        output ADDRESS,
        output WRITEDATA,
        input  READDATA,
        input  BUSYWAIT
    );

    modport slave (
        input  READ,
        input  WRITE,
        input  ADDRESS,
        input  WRITEDATA,
        output READDATA,
        output BUSYWAIT
    );
endinterface

// File: rtl/data_memory.sv
// Block-granular (128-bit) data memory behind the L1 D-cache; DATAMEM_PROFILE_EN adds read/write counters.
// Latency: request accepted at edge 0, access performed LATENCY edges later, DONE cycle follows.
// Backpressure: BUSYWAIT high from request until DONE; one request at a time, inputs ignored while busy.
module data_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic         CLK,
    input  logic         RESET_N,
    data_memory_if.slave bus
`ifdef DATAMEM_PROFILE_EN
    ,
    output logic [31:0]  READ_COUNT,
    output logic [31:0]  WRITE_COUNT
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic [127:0]     wdat;
    } req_t;

    logic [1:0]       rst_sync;
    logic             arst_n;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    req_t             req_q;
    logic [127:0]     rdata_q;
    logic             req_vld;
    logic             access_en;

    logic [127:0]     mem [DEPTH];

    // Assertion is immediate; deassertion is retimed through two flops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign arst_n = rst_sync[1];

    // Upper address bits alias modulo DEPTH.
    generate
        if (IDX_W < 28) begin : g_addr_alias
            logic unused_addr_hi;
            assign unused_addr_hi = &{1'b0, bus.ADDRESS[27:IDX_W]};
        end
    endgenerate

    assign req_vld       = bus.READ | bus.WRITE;
    assign access_en     = (state == ST_BUSY) && (cnt == '0);
    assign bus.BUSYWAIT  = ((state == ST_IDLE) && req_vld) || (state == ST_BUSY);
    assign bus.READDATA  = rdata_q;

    always_ff @(posedge CLK or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        state      <= ST_BUSY;
                        cnt        <= CNT_W'(LATENCY - 1);
                        req_q.wr   <= bus.WRITE;
                        req_q.idx  <= bus.ADDRESS[IDX_W-1:0];
                        req_q.wdat <= bus.WRITEDATA;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        if (!req_q.wr) begin
                            rdata_q <= mem[req_q.idx];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Array is never cleared; a reset before the completion edge drops the write.
    always_ff @(posedge CLK) begin
        if (access_en && req_q.wr) begin
            mem[req_q.idx] <= req_q.wdat;
        end
    end

`ifdef DATAMEM_PROFILE_EN
    logic [31:0] read_cnt;
    logic [31:0] write_cnt;

    always_ff @(posedge CLK or negedge arst_n) begin
        if (!arst_n) begin
            read_cnt  <= '0;
            write_cnt <= '0;
        end else if (access_en) begin
            if (req_q.wr) begin
                if (write_cnt != 32'hFFFF_FFFF) begin
                    write_cnt <= write_cnt + 32'd1;
                end
            end else begin
                if (read_cnt != 32'hFFFF_FFFF) begin
                    read_cnt <= read_cnt + 32'd1;
                end
            end
        end
    end

    assign READ_COUNT  = read_cnt;
    assign WRITE_COUNT = write_cnt;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH=256, LATENCY=5): vector table plus reset, back-to-back and abort sequences.
module tb_data_memory;

    logic CLK;
    logic RESET_N;

    data_memory_if bus();

`ifdef DATAMEM_PROFILE_EN
    logic [31:0] read_count;
    logic [31:0] write_count;
`endif

    data_memory #(
        .DEPTH   (256),
        .LATENCY (5)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
`ifdef DATAMEM_PROFILE_EN
        ,
        .READ_COUNT  (read_count),
        .WRITE_COUNT (write_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks;
    int failures;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdat;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    localparam logic [127:0] D_DEAD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] D_A5   = 128'hA5A5A5A5_00001111_22223333_44445555;
    localparam logic [127:0] D_B2B  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge, drop and scramble inputs after acceptance,
    // count BUSYWAIT-high cycles and return READDATA sampled in DONE.
    task automatic do_txn(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wdat, output int busy, output logic [127:0] rdata);
        @(negedge CLK);
        bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = addr; bus.WRITEDATA = wdat;
        #1;
        busy = 0;
        while (bus.BUSYWAIT === 1'b1 && busy < 50) begin
            busy++;
            @(negedge CLK);
            if (busy == 1) begin
                bus.READ = 1'b0; bus.WRITE = 1'b0;
                bus.ADDRESS = ~addr; bus.WRITEDATA = ~wdat;
            end
            #1;
        end
        rdata = bus.READDATA;
    endtask

    initial begin
        int           busy;
        logic [127:0] rdata;
        logic [15:0]  bw;
        logic [127:0] rd_b2b;

        checks = 0;
        failures = 0;

        vecs[0] = '{rd:1'b0, wr:1'b1, addr:28'h0000012, wdat:D_DEAD,   exp_rd:128'h0};
        vecs[1] = '{rd:1'b1, wr:1'b0, addr:28'h0000012, wdat:128'h0,   exp_rd:D_DEAD};
        vecs[2] = '{rd:1'b0, wr:1'b1, addr:28'h0000003, wdat:128'h1,   exp_rd:D_DEAD};
        vecs[3] = '{rd:1'b1, wr:1'b0, addr:28'h0000103, wdat:128'h0,   exp_rd:128'h1};
        vecs[4] = '{rd:1'b0, wr:1'b1, addr:28'h0000007, wdat:D_A5,     exp_rd:128'h1};
        vecs[5] = '{rd:1'b1, wr:1'b1, addr:28'h0000020, wdat:128'h55,  exp_rd:128'h1};
        vecs[6] = '{rd:1'b1, wr:1'b0, addr:28'h0000020, wdat:128'h0,   exp_rd:128'h55};
        vecs[7] = '{rd:1'b1, wr:1'b0, addr:28'h0000007, wdat:128'h0,   exp_rd:D_A5};
        vecs[8] = '{rd:1'b0, wr:1'b1, addr:28'hFFFFF12, wdat:128'h77,  exp_rd:D_A5};
        vecs[9] = '{rd:1'b1, wr:1'b0, addr:28'h0000012, wdat:128'h0,   exp_rd:128'h77};

        // Reset state
        RESET_N = 1'b0;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = '0; bus.WRITEDATA = '0;
        #3;
        chk("reset_readdata", bus.READDATA, 128'h0);
        chk("reset_busywait", {127'h0, bus.BUSYWAIT}, 128'h0);

        // Release with a write already pending: two sync edges, then acceptance
        @(negedge CLK);
        bus.WRITE = 1'b1; bus.ADDRESS = 28'h0000030; bus.WRITEDATA = 128'h99;
        RESET_N = 1'b1;
        #1;
        busy = 0;
        while (bus.BUSYWAIT === 1'b1 && busy < 50) begin
            busy++;
            @(negedge CLK);
            #1;
        end
        bus.WRITE = 1'b0;
        chk("release_busy_cycles", 128'(busy), 128'd8);
        chk("release_readdata", bus.READDATA, 128'h0);

        // Vector table: busy window and READDATA in DONE
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdat, busy, rdata);
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'd6);
            chk($sformatf("vec%0d_readdata", i), rdata, vecs[i].exp_rd);
        end

        // Back-to-back write-back then refill
        bw = '0;
        rd_b2b = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                bus.WRITE = 1'b1; bus.ADDRESS = 28'h0000040; bus.WRITEDATA = D_B2B;
            end
            if (c == 7) begin
                bus.WRITE = 1'b0; bus.READ = 1'b1;
            end
            if (c == 8) begin
                bus.READ = 1'b0;
            end
            #1;
            bw[c] = bus.BUSYWAIT;
            if (c == 13) rd_b2b = bus.READDATA;
        end
        chk("b2b_busywait_pattern", {112'h0, bw}, {112'h0, 16'h1FBF});
        chk("b2b_readdata", rd_b2b, D_B2B);

        // Mid-access abort: reset in BUSY cycle 3 must drop the write to idx 7
        @(negedge CLK);
        bus.WRITE = 1'b1; bus.ADDRESS = 28'h0000007; bus.WRITEDATA = 128'hFF;
        @(negedge CLK);
        bus.WRITE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("abort_busy_before", {127'h0, bus.BUSYWAIT}, 128'h1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("abort_async_readdata", bus.READDATA, 128'h0);
        chk("abort_async_busywait", {127'h0, bus.BUSYWAIT}, 128'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        do_txn(1'b1, 1'b0, 28'h0000007, 128'h0, busy, rdata);
        chk("abort_read_busy", 128'(busy), 128'd6);
        chk("abort_read_idx7", rdata, D_A5);

`ifdef DATAMEM_PROFILE_EN
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("prof_reset_reads", {96'h0, read_count}, 128'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        do_txn(1'b1, 1'b0, 28'h0000012, 128'h0, busy, rdata);
        do_txn(1'b0, 1'b1, 28'h0000050, 128'h5, busy, rdata);
        do_txn(1'b1, 1'b0, 28'h0000003, 128'h0, busy, rdata);
        do_txn(1'b0, 1'b1, 28'h0000051, 128'h6, busy, rdata);
        do_txn(1'b1, 1'b0, 28'h0000020, 128'h0, busy, rdata);
        chk("prof_read_count", {96'h0, read_count}, 128'd3);
        chk("prof_write_count", {96'h0, write_count}, 128'd2);
        @(negedge CLK);
        force dut.read_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.read_cnt;
        do_txn(1'b1, 1'b0, 28'h0000012, 128'h0, busy, rdata);
        chk("prof_read_to_max", {96'h0, read_count}, {96'h0, 32'hFFFF_FFFF});
        do_txn(1'b1, 1'b0, 28'h0000012, 128'h0, busy, rdata);
        chk("prof_read_saturate", {96'h0, read_count}, {96'h0, 32'hFFFF_FFFF});
        chk("prof_write_unchanged", {96'h0, write_count}, 128'd2);
`endif

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
